// File: rtl/mod_div_unit.sv
// Multi-cycle radix-2 restoring divider returning remainder (MOD) or quotient (DIV).
// Optional two's-complement support is enabled by defining MOD_SIGNED_EN.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured here
// S_RUN  | one shift-subtract step per cycle, WIDTH steps total
// S_DONE | result registered, done pulse high for this cycle
module mod_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // The partial remainder is always below the divisor, so WIDTH bits hold it;
    // only the trial subtraction needs the extra bit.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dz_q, dz_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] res_mod;
    logic [WIDTH-1:0] res_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;

    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        quo_n  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_n  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    end

`ifdef MOD_SIGNED_EN
    always_comb begin
        a_neg   = op[1] & A[WIDTH-1];
        b_neg   = op[1] & B[WIDTH-1];
        a_mag   = a_neg ? (~A + 1'b1) : A;
        b_mag   = b_neg ? (~B + 1'b1) : B;
        // Remainder follows the dividend sign, quotient truncates toward zero.
        res_mod = neg_rem_q ? (~rem_n + 1'b1) : rem_n;
        res_div = neg_quo_q ? (~quo_n + 1'b1) : quo_n;
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1] ^ neg_quo_q ^ neg_rem_q;

    always_comb begin
        a_neg   = 1'b0;
        b_neg   = 1'b0;
        a_mag   = A;
        b_mag   = B;
        res_mod = rem_n;
        res_div = quo_n;
    end
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        result_d  = result_q;
        dz_d      = dz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d = op[0];
                    if (B == '0) begin
                        state_d  = S_DONE;
                        dz_d     = 1'b1;
                        result_d = op[0] ? '1 : A;
                    end else begin
                        state_d   = S_RUN;
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        cnt_d     = CW'(WIDTH - 1);
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end

            S_RUN: begin
                rem_d = rem_n;
                quo_d = quo_n;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    dz_d     = 1'b0;
                    result_d = div_q ? res_div : res_mod;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            result_q  <= result_d;
            dz_q      <= dz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign result = result_q;
    assign dz     = dz_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mod_div_unit.sv
// Scoreboard bench for mod_div_unit: stimulus pushes expected results, a monitor
// pops and compares on every done pulse. Define MOD_SIGNED_EN to exercise signed ops.
module tb_mod_div_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         dz;

    mod_div_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done),
        .dz     (dz)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        int           at_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Division semantics straight from arithmetic; SV / and % on signed longint
    // truncate toward zero with the remainder following the dividend.
    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic z);
        longint sa, sb_v, q, m;
        if (b == '0) begin
            z = 1'b1;
            r = o[0] ? '1 : a;
        end else begin
            z = 1'b0;
            sa   = longint'({32'd0, a});
            sb_v = longint'({32'd0, b});
`ifdef MOD_SIGNED_EN
            if (o[1]) begin
                sa   = longint'($signed(a));
                sb_v = longint'($signed(b));
            end
`endif
            q = sa / sb_v;
            m = sa % sb_v;
            r = o[0] ? q[W-1:0] : m[W-1:0];
        end
    endfunction

    always @(negedge CLK) begin
        if (done) begin
            exp_t e;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done=1 result=%h dz=%b, expected no completion", result, dz);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || dz !== e.z || cyc != e.at_cyc) begin
                    n_bad++;
                    $display("FAIL completion: got result=%h dz=%b cycle=%0d, expected result=%h dz=%b cycle=%0d",
                             result, dz, cyc, e.res, e.z, e.at_cyc);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the sampling edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track);
        exp_t e;
        logic [W-1:0] r;
        logic z;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (track) begin
            ref_model(o, a, b, r, z);
            e.res    = r;
            e.z      = z;
            e.at_cyc = cyc + 1 + ((b == '0) ? 0 : W);
            sb.push_back(e);
        end
        @(negedge CLK);
        start = 1'b0;
        op    = 2'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle(input int exp_busy);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL busy_timeout: busy still high after %0d cycles, expected release", n);
        end else if (exp_busy >= 0) begin
            check_val("busy_cycles", W'(n), W'(exp_busy));
        end
    endtask

    initial begin
        logic [1:0]   o;
        logic [W-1:0] a, b;

        repeat (2) @(negedge CLK);
        check_val("rst_result", result, '0);
        check_val("rst_flags", {29'd0, busy, done, dz}, '0);
        RST = 1'b0;
        @(negedge CLK);

        issue(2'b00, 32'd100, 32'd7, 1'b1);
        wait_idle(W + 1);
        issue(2'b01, 32'hFFFF_FFFF, 32'h10, 1'b1);
        wait_idle(W + 1);
        issue(2'b00, 32'd5, 32'd9, 1'b1);
        wait_idle(W + 1);
        check_val("mod_5_9", result, 32'd5);

        issue(2'b00, 32'h1234, 32'd0, 1'b1);
        wait_idle(1);
        issue(2'b01, 32'h1234, 32'd0, 1'b1);
        wait_idle(1);
        check_val("dz_div_result", result, 32'hFFFF_FFFF);

        issue(2'b00, 32'd100, 32'd7, 1'b1);
        repeat (5) @(negedge CLK);
        start = 1'b1; op = 2'b00; A = 32'd50; B = 32'd3;
        @(negedge CLK);
        start = 1'b0;
        wait_idle(-1);
        check_val("ignored_start_result", result, 32'd2);

        issue(2'b00, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_val("midrun_rst_result", result, '0);
        check_val("midrun_rst_flags", {29'd0, busy, done, dz}, '0);
        RST = 1'b0;
        repeat (W + 4) @(negedge CLK);
        issue(2'b00, 32'd100, 32'd7, 1'b1);
        wait_idle(W + 1);

        RST = 1'b1; start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd0;
        @(negedge CLK);
        check_val("rst_start_flags", {29'd0, busy, done, dz}, '0);
        RST = 1'b0; start = 1'b0;
        repeat (3) @(negedge CLK);

        issue(2'b10, 32'hFFFF_FFF9, 32'd3, 1'b1);
        wait_idle(W + 1);
        issue(2'b11, 32'hFFFF_FFF9, 32'd3, 1'b1);
        wait_idle(W + 1);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle(W + 1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle(W + 1);
        issue(2'b10, 32'h8000_0000, 32'd0, 1'b1);
        wait_idle(1);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b == '0 && $urandom_range(0, 1) == 1) b = 32'd1;
            issue(o, a, b, 1'b1);
            wait_idle((b == '0) ? 1 : W + 1);
        end

        repeat (3) @(negedge CLK);
        check_val("scoreboard_drained", W'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
